// File: rtl/dpseq_pkg.sv
// Shared definitions for the datapath sequencer: instruction word layout, FSM encoding and helpers.
package dpseq_pkg;

    localparam int INSTR_W = 11;

    // Field order follows the instruction word from bit 10 down to bit 0.
    typedef struct packed {
        logic [2:0] aluc;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        logic       wb;
        logic       cond;
    } instr_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    function automatic logic write_enable(input logic wb, input logic cond, input logic zf);
        return wb & (cond ? zf : 1'b1);
    endfunction

endpackage

// File: rtl/dpseq_fifo.sv
// Synchronous instruction FIFO with occupancy count; a push while full is dropped even if popping.
module dpseq_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign dout   = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Issues buffered instruction words onto the ALU/register-file control inputs, two cycles each.
// Optional sticky zero flag and conditional write: define DATAPATH_SEQ_ZFLAG_EN.
module datapath_sequencer
    import dpseq_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_W     = 2,
    parameter int ALUC_W     = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    input  logic [WORD_SIZE-1:0] result,
    output logic [ALUC_W-1:0]    alucontrol,
    output logic [ADDR_W-1:0]    addr1,
    output logic [ADDR_W-1:0]    addr2,
    output logic [ADDR_W-1:0]    addr3,
    output logic                 wr,
    output logic                 busy,
    output logic                 done,
    output logic                 zflag,
    output logic [CNT_W-1:0]     fifo_count
);

    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [INSTR_W-1:0] head_bits_s;
    instr_t             head_s;
    logic               wb_r;
    logic               cond_r;
    logic               wr_calc_s;
    logic [ALUC_W-1:0]  aluc_r;
    logic [ADDR_W-1:0]  a1_r;
    logic [ADDR_W-1:0]  a2_r;
    logic [ADDR_W-1:0]  a3_r;
    logic               wr_r;
    logic               done_r;

    dpseq_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (instr_valid),
        .pop   (pop_s),
        .din   (instr),
        .dout  (head_bits_s),
        .count (fifo_count),
        .full  (full_s),
        .empty (empty_s)
    );

    assign head_s      = instr_t'(head_bits_s);
    assign instr_ready = ~full_s;
    assign busy        = (state_r != ST_IDLE) | ~empty_s;
    assign alucontrol  = aluc_r;
    assign addr1       = a1_r;
    assign addr2       = a2_r;
    assign addr3       = a3_r;
    assign wr          = wr_r;
    assign done        = done_r;

    // Next state and FIFO pop; a pop happens on every entry into ISSUE.
    always_comb begin
        pop_s      = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx_s = ST_WRITE;
            ST_WRITE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

`ifdef DATAPATH_SEQ_ZFLAG_EN
    logic zflag_r;

    assign wr_calc_s = write_enable(wb_r, cond_r, zflag_r);
    assign zflag     = zflag_r;

    // Zero flag captures the result of each write actually performed, at the end of WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zflag_r <= 1'b0;
        end else if ((state_r == ST_WRITE) && wr_r) begin
            zflag_r <= (result == {WORD_SIZE{1'b0}});
        end else begin
            zflag_r <= zflag_r;
        end
    end
`else
    logic unused_inputs_s;

    assign wr_calc_s       = wb_r;
    assign zflag           = 1'b0;
    assign unused_inputs_s = ^{result, cond_r};
`endif

    // FSM state, latched instruction fields and the registered write/done strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            aluc_r  <= {ALUC_W{1'b0}};
            a1_r    <= {ADDR_W{1'b0}};
            a2_r    <= {ADDR_W{1'b0}};
            a3_r    <= {ADDR_W{1'b0}};
            wb_r    <= 1'b0;
            cond_r  <= 1'b0;
            wr_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (pop_s) begin
                aluc_r <= ALUC_W'(head_s.aluc);
                a1_r   <= ADDR_W'(head_s.a1);
                a2_r   <= ADDR_W'(head_s.a2);
                a3_r   <= ADDR_W'(head_s.a3);
                wb_r   <= head_s.wb;
                cond_r <= head_s.cond;
            end
            // Strobes are set on the ISSUE->WRITE edge so they are high exactly during WRITE.
            if (state_r == ST_ISSUE) begin
                wr_r   <= wr_calc_s;
                done_r <= 1'b1;
            end else begin
                wr_r   <= 1'b0;
                done_r <= 1'b0;
            end
        end
    end

endmodule
